// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared constants and divisor validation for clock_div_cascade
package clock_div_pkg;

  localparam int DIV_US = 100;
  localparam int DIV_MS = 1000;
  localparam int DIV_S  = 1000;
  localparam int DIV_W  = 16;

  // A 50 % duty output needs an even divisor of at least two.
  function automatic bit div_valid(input int unsigned d);
    return (d >= 2) && (d[0] == 1'b0);
  endfunction

endpackage

// File: rtl/clock_div_stage.sv
// rtl/clock_div_stage.sv - one divide-by-D stage: counter, divided clock, edge and terminal strobes
module clock_div_stage
  import clock_div_pkg::*;
#(
  parameter int D = DIV_US
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic adv,
  output logic div_clk,
  output logic pedge,
  output logic nedge,
  output logic tick
);

  localparam int W = $clog2(D);
  localparam logic [W-1:0] LAST = W'(D - 1);
  localparam logic [W-1:0] HALF = W'(D / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         div_clk_q, div_clk_d;
  logic         div_clk_dly_q;
  logic         wrap;

  always_comb begin
    wrap      = (cnt_q == LAST);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    div_clk_d = (cnt_d >= HALF);
  end

  // The delayed copy tracks every cycle so each edge strobe lasts exactly one clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      div_clk_q     <= 1'b0;
      div_clk_dly_q <= 1'b0;
    end else if (clr) begin
      cnt_q         <= '0;
      div_clk_q     <= 1'b0;
      div_clk_dly_q <= 1'b0;
    end else begin
      if (adv) begin
        cnt_q     <= cnt_d;
        div_clk_q <= div_clk_d;
      end
      div_clk_dly_q <= div_clk_q;
    end
  end

  assign div_clk = div_clk_q;
  assign pedge   = div_clk_q & ~div_clk_dly_q;
  assign nedge   = ~div_clk_q & div_clk_dly_q;
  assign tick    = adv & wrap & ~clr;

endmodule

// File: rtl/clock_div_cascade.sv
// rtl/clock_div_cascade.sv - cascade of clock_div_stage dividers, each advancing on the previous tick
module clock_div_cascade
  import clock_div_pkg::*;
#(
  parameter int                      STAGES = 3,
  parameter int                      DIV_W  = clock_div_pkg::DIV_W,
  parameter logic [STAGES*DIV_W-1:0] DIVS   = {DIV_W'(DIV_S), DIV_W'(DIV_MS), DIV_W'(DIV_US)}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  output logic [STAGES-1:0] div_clk,
  output logic [STAGES-1:0] pedge,
  output logic [STAGES-1:0] nedge,
  output logic [STAGES-1:0] tick
);

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "clock_div_cascade: STAGES must be at least 1");
  end

  logic [STAGES-1:0] adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int D = int'(DIVS[k*DIV_W +: DIV_W]);

    if (!div_valid(D)) begin : g_bad_div
      $fatal(1, "clock_div_cascade: stage divisor must be even and at least 2");
    end

    // The ticks chain combinationally so all stages wrap in the same cycle.
    if (k == 0) begin : g_head
      assign adv[k] = en;
    end else begin : g_link
      assign adv[k] = tick[k-1];
    end

    clock_div_stage #(
      .D(D)
    ) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (clr),
      .adv    (adv[k]),
      .div_clk(div_clk[k]),
      .pedge  (pedge[k]),
      .nedge  (nedge[k]),
      .tick   (tick[k])
    );
  end

endmodule

// File: tb/tb_clock_div_cascade.sv
// tb/tb_clock_div_cascade.sv - scoreboard bench for clock_div_cascade
module tb_clock_div_cascade;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic clr;

  logic [2:0] def_div_clk, def_pedge, def_nedge, def_tick;
  logic [2:0] sm_div_clk, sm_pedge, sm_nedge, sm_tick;
  logic [0:0] d2_div_clk, d2_pedge, d2_nedge, d2_tick;

  int checks = 0;
  int errors = 0;
  int exp_q[5][$];

  always #5 clk = ~clk;

  clock_div_cascade u_def (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .div_clk(def_div_clk), .pedge(def_pedge), .nedge(def_nedge), .tick(def_tick)
  );

  clock_div_cascade #(
    .STAGES(3), .DIV_W(16), .DIVS({16'd6, 16'd4, 16'd10})
  ) u_small (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .div_clk(sm_div_clk), .pedge(sm_pedge), .nedge(sm_nedge), .tick(sm_tick)
  );

  clock_div_cascade #(
    .STAGES(1), .DIV_W(16), .DIVS(16'd2)
  ) u_d2 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .div_clk(d2_div_clk), .pedge(d2_pedge), .nedge(d2_nedge), .tick(d2_tick)
  );

  task automatic clear_q();
    for (int c = 0; c < 5; c++) exp_q[c].delete();
  endtask

  // Releases reset right after a falling edge; the caller samples cycle 0 immediately.
  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({def_div_clk, sm_div_clk, d2_div_clk} !== 7'b0) begin
      errors++; $display("FAIL reset div_clk: got %b want 0", {def_div_clk, sm_div_clk, d2_div_clk});
    end
    checks++;
    if ({def_pedge, sm_pedge, d2_pedge} !== 7'b0) begin
      errors++; $display("FAIL reset pedge: got %b want 0", {def_pedge, sm_pedge, d2_pedge});
    end
    checks++;
    if ({def_nedge, sm_nedge, d2_nedge} !== 7'b0) begin
      errors++; $display("FAIL reset nedge: got %b want 0", {def_nedge, sm_nedge, d2_nedge});
    end
    checks++;
    if ({def_tick, sm_tick, d2_tick} !== 7'b0) begin
      errors++; $display("FAIL reset tick: got %b want 0", {def_tick, sm_tick, d2_tick});
    end
  endtask

  // ch0 tick[0], ch1 pedge[0], ch2 nedge[0]
  task automatic test_default();
    logic       exp_lv;
    logic [2:0] obs;
    int         e;
    clear_q();
    for (int m = 1; m <= 10; m++) begin
      exp_q[0].push_back(100 * m - 1);
      exp_q[1].push_back(100 * (m - 1) + 50);
      exp_q[2].push_back(100 * m);
    end
    do_reset();
    for (int s = 0; s <= 1000; s++) begin
      if (s > 0) @(negedge clk);
      exp_lv = ((s % 100) >= 50);
      checks++;
      if (def_div_clk[0] !== exp_lv) begin
        errors++; $display("FAIL default div_clk0 cycle %0d: got %b want %b", s, def_div_clk[0], exp_lv);
      end
      obs = {def_nedge[0], def_pedge[0], def_tick[0]};
      for (int c = 0; c < 3; c++) begin
        if (obs[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++; $display("FAIL default ch%0d: strobe at cycle %0d, want none", c, s);
          end else begin
            e = exp_q[c].pop_front();
            if (e != s) begin
              errors++; $display("FAIL default ch%0d: strobe at cycle %0d, want cycle %0d", c, s, e);
            end
          end
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++; $display("FAIL default ch%0d: no strobe, want cycle %0d", c, exp_q[c][0]);
      end
    end
  endtask

  // ch0..2 tick[0..2], ch3 pedge[2], ch4 nedge[2]
  task automatic test_cascade();
    logic       exp_lv;
    logic [4:0] obs;
    int         e;
    clear_q();
    for (int i = 0; i < 24; i++) exp_q[0].push_back(10 * i + 9);
    for (int i = 0; i < 6; i++)  exp_q[1].push_back(40 * i + 39);
    exp_q[2].push_back(239);
    exp_q[3].push_back(120);
    exp_q[4].push_back(240);
    do_reset();
    for (int s = 0; s <= 240; s++) begin
      if (s > 0) @(negedge clk);
      exp_lv = (s >= 120) && (s <= 239);
      checks++;
      if (sm_div_clk[2] !== exp_lv) begin
        errors++; $display("FAIL cascade div_clk2 cycle %0d: got %b want %b", s, sm_div_clk[2], exp_lv);
      end
      obs = {sm_nedge[2], sm_pedge[2], sm_tick[2], sm_tick[1], sm_tick[0]};
      for (int c = 0; c < 5; c++) begin
        if (obs[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++; $display("FAIL cascade ch%0d: strobe at cycle %0d, want none", c, s);
          end else begin
            e = exp_q[c].pop_front();
            if (e != s) begin
              errors++; $display("FAIL cascade ch%0d: strobe at cycle %0d, want cycle %0d", c, s, e);
            end
          end
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++; $display("FAIL cascade ch%0d: no strobe, want cycle %0d", c, exp_q[c][0]);
      end
    end
  endtask

  // en dropped after cnt reaches 30, for 7 edges
  task automatic test_enable();
    logic       exp_lv;
    logic [2:0] obs;
    int         e;
    int         n;
    clear_q();
    exp_q[0].push_back(106);
    exp_q[1].push_back(57);
    exp_q[1].push_back(157);
    exp_q[2].push_back(107);
    do_reset();
    for (int s = 0; s <= 157; s++) begin
      if (s > 0) @(negedge clk);
      n = (s <= 30) ? s : ((s <= 37) ? 30 : s - 7);
      exp_lv = ((n % 100) >= 50);
      checks++;
      if (def_div_clk[0] !== exp_lv) begin
        errors++; $display("FAIL enable div_clk0 cycle %0d: got %b want %b", s, def_div_clk[0], exp_lv);
      end
      obs = {def_nedge[0], def_pedge[0], def_tick[0]};
      for (int c = 0; c < 3; c++) begin
        if (obs[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++; $display("FAIL enable ch%0d: strobe at cycle %0d, want none", c, s);
          end else begin
            e = exp_q[c].pop_front();
            if (e != s) begin
              errors++; $display("FAIL enable ch%0d: strobe at cycle %0d, want cycle %0d", c, s, e);
            end
          end
        end
      end
      if (s == 30) en = 1'b0;
      if (s == 37) en = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++; $display("FAIL enable ch%0d: no strobe, want cycle %0d", c, exp_q[c][0]);
      end
    end
  endtask

  // clr pulse while cnt[0] = 60 and div_clk[0] = 1
  task automatic test_clear();
    logic       exp_lv;
    logic [2:0] obs;
    int         e;
    int         n;
    clear_q();
    exp_q[0].push_back(160);
    exp_q[1].push_back(50);
    exp_q[1].push_back(111);
    exp_q[2].push_back(161);
    do_reset();
    for (int s = 0; s <= 161; s++) begin
      if (s > 0) @(negedge clk);
      n = (s <= 60) ? s : s - 61;
      exp_lv = ((n % 100) >= 50);
      checks++;
      if (def_div_clk[0] !== exp_lv) begin
        errors++; $display("FAIL clear div_clk0 cycle %0d: got %b want %b", s, def_div_clk[0], exp_lv);
      end
      obs = {def_nedge[0], def_pedge[0], def_tick[0]};
      for (int c = 0; c < 3; c++) begin
        if (obs[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++; $display("FAIL clear ch%0d: strobe at cycle %0d, want none", c, s);
          end else begin
            e = exp_q[c].pop_front();
            if (e != s) begin
              errors++; $display("FAIL clear ch%0d: strobe at cycle %0d, want cycle %0d", c, s, e);
            end
          end
        end
      end
      if (s == 60) clr = 1'b1;
      if (s == 61) clr = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++; $display("FAIL clear ch%0d: no strobe, want cycle %0d", c, exp_q[c][0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic       exp_lv;
    logic [2:0] obs;
    int         e;
    do_reset();
    repeat (70) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({def_div_clk, def_pedge, def_nedge, def_tick} !== 12'b0) begin
      errors++; $display("FAIL async_reset immediate: got %b want 0", {def_div_clk, def_pedge, def_nedge, def_tick});
    end
    @(negedge clk);
    checks++;
    if ({def_div_clk, def_pedge, def_nedge, def_tick} !== 12'b0) begin
      errors++; $display("FAIL async_reset held: got %b want 0", {def_div_clk, def_pedge, def_nedge, def_tick});
    end
    reset_n = 1'b1;
    clear_q();
    for (int m = 1; m <= 2; m++) begin
      exp_q[0].push_back(100 * m - 1);
      exp_q[1].push_back(100 * (m - 1) + 50);
      exp_q[2].push_back(100 * m);
    end
    for (int s = 0; s <= 200; s++) begin
      if (s > 0) @(negedge clk);
      exp_lv = ((s % 100) >= 50);
      checks++;
      if (def_div_clk[0] !== exp_lv) begin
        errors++; $display("FAIL async_reset div_clk0 cycle %0d: got %b want %b", s, def_div_clk[0], exp_lv);
      end
      obs = {def_nedge[0], def_pedge[0], def_tick[0]};
      for (int c = 0; c < 3; c++) begin
        if (obs[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++; $display("FAIL async_reset ch%0d: strobe at cycle %0d, want none", c, s);
          end else begin
            e = exp_q[c].pop_front();
            if (e != s) begin
              errors++; $display("FAIL async_reset ch%0d: strobe at cycle %0d, want cycle %0d", c, s, e);
            end
          end
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++; $display("FAIL async_reset ch%0d: no strobe, want cycle %0d", c, exp_q[c][0]);
      end
    end
  endtask

  task automatic test_div2();
    logic odd;
    do_reset();
    for (int s = 0; s <= 20; s++) begin
      if (s > 0) @(negedge clk);
      odd = (s % 2) == 1;
      checks++;
      if (d2_div_clk[0] !== odd) begin
        errors++; $display("FAIL div2 div_clk cycle %0d: got %b want %b", s, d2_div_clk[0], odd);
      end
      checks++;
      if (d2_pedge[0] !== odd) begin
        errors++; $display("FAIL div2 pedge cycle %0d: got %b want %b", s, d2_pedge[0], odd);
      end
      checks++;
      if (d2_nedge[0] !== (!odd && s > 0)) begin
        errors++; $display("FAIL div2 nedge cycle %0d: got %b want %b", s, d2_nedge[0], (!odd && s > 0));
      end
      checks++;
      if (d2_tick[0] !== odd) begin
        errors++; $display("FAIL div2 tick cycle %0d: got %b want %b", s, d2_tick[0], odd);
      end
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (d2_tick[0] !== 1'b0) begin
      errors++; $display("FAIL div2 tick in clr cycle: got %b want 0", d2_tick[0]);
    end
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if ({d2_div_clk[0], d2_nedge[0]} !== 2'b00) begin
      errors++; $display("FAIL div2 after clr div_clk/nedge: got %b want 00", {d2_div_clk[0], d2_nedge[0]});
    end
    @(negedge clk);
    checks++;
    if ({d2_div_clk[0], d2_pedge[0]} !== 2'b11) begin
      errors++; $display("FAIL div2 restart div_clk/pedge: got %b want 11", {d2_div_clk[0], d2_pedge[0]});
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cascade();
    test_enable();
    test_clear();
    test_async_reset();
    test_div2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
